// File: rtl/cpu_defs.sv
// Shared definitions for the 5-stage CPU datapath.
// Holds the datapath widths, the ALUFun encodings understood by the EX-stage
// ALU, and the bundle of controls that flows from ID towards MEM/WB.
package cpu_defs;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int FUN_W   = 6;
  localparam int SHAMT_W = 5;

  // ALUFun encodings. ALU_ADD is all zeros so a cleared pipeline register
  // (bubble) decodes to an add of zero operands, which has no side effects.
  localparam logic [FUN_W-1:0] ALU_ADD = 6'b000000;
  localparam logic [FUN_W-1:0] ALU_SUB = 6'b000001;
  localparam logic [FUN_W-1:0] ALU_AND = 6'b011000;
  localparam logic [FUN_W-1:0] ALU_OR  = 6'b011110;
  localparam logic [FUN_W-1:0] ALU_XOR = 6'b010110;
  localparam logic [FUN_W-1:0] ALU_NOR = 6'b010001;
  localparam logic [FUN_W-1:0] ALU_A   = 6'b011010;
  localparam logic [FUN_W-1:0] ALU_SLL = 6'b100000;
  localparam logic [FUN_W-1:0] ALU_SRL = 6'b100001;
  localparam logic [FUN_W-1:0] ALU_SRA = 6'b100011;
  localparam logic [FUN_W-1:0] ALU_EQ  = 6'b110011;
  localparam logic [FUN_W-1:0] ALU_NEQ = 6'b110001;
  localparam logic [FUN_W-1:0] ALU_LT  = 6'b110101;

  // Downstream control bundle, field order MSB to LSB.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{reg_write: 1'b0, mem_read: 1'b0,
                                 mem_write: 1'b0, mem_to_reg: 1'b0};

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding selector for one source register.
// Picks the youngest in-flight producer of src_addr: EX, then MEM, then WB,
// otherwise the register-file read data. Register 0 never forwards.
// Ports:
//   src_addr   source register number read by the ID instruction
//   rf_data    register-file read data for src_addr
//   ex_fwd_en  EX holds a valid non-load writer (result already computed)
//   ex_rd/ex_data    EX destination and ALU result
//   mem_we/mem_rd/mem_data   MEM-stage writer
//   wb_we/wb_rd/wb_data      WB-stage writer
//   fwd_data   resolved operand value
module fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic [RADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]  rf_data,
  input  logic               ex_fwd_en,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0]  ex_data,
  input  logic               mem_we,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]  mem_data,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]  wb_data,
  output logic [DATA_W-1:0]  fwd_data
);

  logic src_nz;

  assign src_nz = (src_addr != '0);

  always_comb begin
    fwd_data = rf_data;
    if (src_nz) begin
      if (ex_fwd_en && (ex_rd == src_addr)) begin
        fwd_data = ex_data;
      end else if (mem_we && (mem_rd == src_addr)) begin
        fwd_data = mem_data;
      end else if (wb_we && (wb_rd == src_addr)) begin
        fwd_data = wb_data;
      end
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU.
// Resolves forwarding for rs/rt, applies ALUSrc selection and registers clean
// operands, ALUFun, destination and downstream controls, so the ALU sees only
// flop outputs. Detects load-use hazards and inserts a single bubble.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   id_*                  decoded instruction from ID
//   exf_result            ALU result of the instruction now in EX
//   memf_*, wbf_*         MEM / WB writer for forwarding
//   stall, flush          hold this stage / squash the incoming instruction
//   load_use              combinational hazard, upstream holds PC and IF/ID
//   ex_valid, alu_a, alu_b, alu_fun, ex_store_data, ex_rd, ex_*  registered
module id_ex_operand_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int FUN_W   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs_addr,
  input  logic [RADDR_W-1:0] id_rt_addr,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [4:0]         id_shamt,
  input  logic               id_alusrc1,
  input  logic               id_alusrc2,
  input  logic [FUN_W-1:0]   id_alu_fun,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic [DATA_W-1:0]  exf_result,
  input  logic               memf_reg_write,
  input  logic [RADDR_W-1:0] memf_rd,
  input  logic [DATA_W-1:0]  memf_data,
  input  logic               wbf_reg_write,
  input  logic [RADDR_W-1:0] wbf_rd,
  input  logic [DATA_W-1:0]  wbf_data,
  input  logic               stall,
  input  logic               flush,
  output logic               load_use,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [FUN_W-1:0]   alu_fun,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [RADDR_W-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg
);

  import cpu_defs::*;

  ctrl_t              ex_ctrl;
  ctrl_t              id_ctrl;
  logic               ex_fwd_en;
  logic [DATA_W-1:0]  rs_fwd;
  logic [DATA_W-1:0]  rt_fwd;
  logic [DATA_W-1:0]  a_next;
  logic [DATA_W-1:0]  b_next;
  logic               rs_hit;
  logic               rt_hit;
  logic               do_bubble;
  logic               do_capture;

  assign id_ctrl = '{reg_write: id_reg_write, mem_read: id_mem_read,
                     mem_write: id_mem_write, mem_to_reg: id_mem_to_reg};

  // A load in EX has no result yet; it is picked up from MEM a cycle later.
  assign ex_fwd_en = ex_valid & ex_ctrl.reg_write & ~ex_ctrl.mem_read;

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rs (
    .src_addr  (id_rs_addr),
    .rf_data   (id_rs_data),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_data   (exf_result),
    .mem_we    (memf_reg_write),
    .mem_rd    (memf_rd),
    .mem_data  (memf_data),
    .wb_we     (wbf_reg_write),
    .wb_rd     (wbf_rd),
    .wb_data   (wbf_data),
    .fwd_data  (rs_fwd)
  );

  fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_rt (
    .src_addr  (id_rt_addr),
    .rf_data   (id_rt_data),
    .ex_fwd_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_data   (exf_result),
    .mem_we    (memf_reg_write),
    .mem_rd    (memf_rd),
    .mem_data  (memf_data),
    .wb_we     (wbf_reg_write),
    .wb_rd     (wbf_rd),
    .wb_data   (wbf_data),
    .fwd_data  (rt_fwd)
  );

  assign a_next = id_alusrc1 ? {{(DATA_W-5){1'b0}}, id_shamt} : rs_fwd;
  assign b_next = id_alusrc2 ? id_imm : rt_fwd;

  assign rs_hit   = id_uses_rs & (ex_rd == id_rs_addr);
  assign rt_hit   = id_uses_rt & (ex_rd == id_rt_addr);
  assign load_use = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rd != '0)
                  & (rs_hit | rt_hit);

  // Flush beats stall; stall beats the load-use bubble so the hazard stays
  // visible until the stage is released. Invalid ID slots become bubbles.
  assign do_bubble  = flush | (~stall & (load_use | ~id_valid));
  assign do_capture = ~flush & ~stall & ~load_use & id_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_fun       <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_ctrl       <= CTRL_NOP;
    end else if (do_bubble) begin
      ex_valid      <= 1'b0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_fun       <= FUN_W'(ALU_ADD);
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_ctrl       <= CTRL_NOP;
    end else if (do_capture) begin
      ex_valid      <= 1'b1;
      alu_a         <= a_next;
      alu_b         <= b_next;
      alu_fun       <= id_alu_fun;
      ex_store_data <= rt_fwd;
      ex_rd         <= id_rd_addr;
      ex_ctrl       <= id_ctrl;
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_uses_rs, id_uses_rt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt;
  logic        id_alusrc1, id_alusrc2;
  logic [5:0]  id_alu_fun;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [31:0] exf_result;
  logic        memf_reg_write;
  logic [4:0]  memf_rd;
  logic [31:0] memf_data;
  logic        wbf_reg_write;
  logic [4:0]  wbf_rd;
  logic [31:0] wbf_data;
  logic        stall, flush;
  logic        load_use, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_fun;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2),
    .id_alu_fun(id_alu_fun), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .exf_result(exf_result),
    .memf_reg_write(memf_reg_write), .memf_rd(memf_rd), .memf_data(memf_data),
    .wbf_reg_write(wbf_reg_write), .wbf_rd(wbf_rd), .wbf_data(wbf_data),
    .stall(stall), .flush(flush), .load_use(load_use), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_alusrc1 = 0; id_alusrc2 = 0; id_alu_fun = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    exf_result = 0; memf_reg_write = 0; memf_rd = 0; memf_data = 0;
    wbf_reg_write = 0; wbf_rd = 0; wbf_data = 0; stall = 0; flush = 0;
  endtask

  // Present a plain ALU instruction writing rd with reg_write set.
  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = 1; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_uses_rs = 1; id_uses_rt = 1; id_reg_write = rw; id_mem_read = mr;
    id_mem_to_reg = mr; id_mem_write = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr_inputs();
    reset = 0;
    #2;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_load_use", {31'b0, load_use}, 32'h0);
    @(negedge clk);
    reset = 1;

    // Forward priority: EX > MEM > WB for rs = 5.
    set_instr(5'd1, 5'd2, 5'd5, 1, 0);
    step();
    chk("cap_ex_rd", {27'b0, ex_rd}, 32'd5);
    set_instr(5'd5, 5'd0, 5'd0, 0, 0);
    id_rs_data = 32'h0000_0AAA; id_alu_fun = 6'b000001;
    exf_result = 32'h0000_1234;
    memf_reg_write = 1; memf_rd = 5; memf_data = 32'h0000_5678;
    wbf_reg_write = 1; wbf_rd = 5; wbf_data = 32'h0000_9ABC;
    step();
    chk("fwd_ex", alu_a, 32'h0000_1234);
    chk("fwd_fun", {26'b0, alu_fun}, 32'h1);
    step();
    chk("fwd_mem", alu_a, 32'h0000_5678);
    memf_reg_write = 0;
    step();
    chk("fwd_wb", alu_a, 32'h0000_9ABC);
    wbf_reg_write = 0;
    step();
    chk("fwd_rf", alu_a, 32'h0000_0AAA);

    // Zero register never forwards.
    set_instr(5'd1, 5'd2, 5'd0, 1, 0);
    step();
    set_instr(5'd0, 5'd0, 5'd3, 1, 0);
    id_rs_data = 0; exf_result = 32'hFFFF_FFFF;
    memf_reg_write = 1; memf_rd = 0; memf_data = 32'hFFFF_FFFF;
    wbf_reg_write = 1; wbf_rd = 0; wbf_data = 32'hFFFF_FFFF;
    step();
    chk("zero_reg", alu_a, 32'h0);
    memf_reg_write = 0; wbf_reg_write = 0;

    // Load-use: lw r8 in EX, ID reads r8.
    clr_inputs();
    set_instr(5'd1, 5'd2, 5'd8, 1, 1);
    step();
    set_instr(5'd8, 5'd0, 5'd9, 1, 0);
    id_uses_rt = 0; id_rs_data = 32'h0000_0001; exf_result = 32'h0BAD_0BAD;
    #1;
    chk("lu_assert", {31'b0, load_use}, 32'h1);
    step();
    chk("lu_bubble_valid", {31'b0, ex_valid}, 32'h0);
    chk("lu_bubble_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'h0);
    chk("lu_bubble_a", alu_a, 32'h0);
    chk("lu_clear", {31'b0, load_use}, 32'h0);
    memf_reg_write = 1; memf_rd = 8; memf_data = 32'hDEAD_BEEF;
    step();
    chk("lu_mem_fwd", alu_a, 32'hDEAD_BEEF);
    chk("lu_valid", {31'b0, ex_valid}, 32'h1);
    memf_reg_write = 0;

    // Stall for 3 cycles holds everything.
    clr_inputs();
    set_instr(5'd3, 5'd4, 5'd7, 1, 0);
    id_rs_data = 32'h0000_0033; id_rt_data = 32'h0000_0044; id_alu_fun = 6'b011000;
    step();
    chk("pre_stall_a", alu_a, 32'h0000_0033);
    stall = 1;
    id_rs_data = 32'h5555_5555; id_rt_data = 32'h6666_6666; id_rd_addr = 5'd12;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_a", alu_a, 32'h0000_0033);
      chk("stall_b", alu_b, 32'h0000_0044);
      chk("stall_rd", {27'b0, ex_rd}, 32'd7);
    end
    flush = 1;
    step();
    chk("flush_valid", {31'b0, ex_valid}, 32'h0);
    chk("flush_a", alu_a, 32'h0);
    chk("flush_rw", {31'b0, ex_reg_write}, 32'h0);

    // Stall with load-use pending: hold, hazard stays asserted.
    clr_inputs();
    set_instr(5'd1, 5'd2, 5'd8, 1, 1);
    id_rs_data = 32'h0000_00AB;
    step();
    set_instr(5'd0, 5'd8, 5'd9, 1, 0);
    id_uses_rs = 0;
    stall = 1;
    step();
    chk("stall_lu_hold", {31'b0, load_use}, 32'h1);
    chk("stall_lu_rd", {27'b0, ex_rd}, 32'd8);
    stall = 0;
    step();
    chk("stall_lu_bubble", {31'b0, ex_valid}, 32'h0);

    // ALUSrc selection and store data.
    clr_inputs();
    set_instr(5'd6, 5'd9, 5'd10, 1, 0);
    id_alusrc1 = 1; id_shamt = 5'd3; id_rs_data = 32'h7777_7777;
    id_alusrc2 = 1; id_imm = 32'hFFFF_FFF0; id_rt_data = 32'h0000_0022;
    memf_reg_write = 1; memf_rd = 9; memf_data = 32'h0000_0011;
    id_mem_write = 1;
    step();
    chk("src_a_shamt", alu_a, 32'h0000_0003);
    chk("src_b_imm", alu_b, 32'hFFFF_FFF0);
    chk("src_store", ex_store_data, 32'h0000_0011);
    chk("src_mem_write", {31'b0, ex_mem_write}, 32'h1);

    // Invalid ID slot becomes a bubble.
    id_valid = 0;
    step();
    chk("inv_bubble_b", alu_b, 32'h0);
    chk("inv_bubble_ctrl", {28'b0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'h0);

    // Reset asserted between edges clears outputs immediately.
    clr_inputs();
    set_instr(5'd1, 5'd2, 5'd8, 1, 1);
    id_rs_data = 32'h1234_5678;
    step();
    set_instr(5'd8, 5'd0, 5'd3, 1, 0);
    #2;
    reset = 0;
    #1;
    chk("mid_rst_valid", {31'b0, ex_valid}, 32'h0);
    chk("mid_rst_a", alu_a, 32'h0);
    chk("mid_rst_rd", {27'b0, ex_rd}, 32'h0);
    chk("mid_rst_lu", {31'b0, load_use}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
